// File: rtl/sodor5_verif_pkg.sv
// sodor5_verif_pkg: shared state encoding, constants and LFSR helpers for the sodor5 stimulus sequencer.
package sodor5_verif_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RF_INIT,
        S_DMEM_INIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_POLY : 32'd0);
    endfunction

    // An all-zero state would lock the LFSR, so zero seeds become 1.
    function automatic logic [31:0] fix_seed(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/sodor5_lfsr32.sv
// sodor5_lfsr32: 32-bit Galois LFSR with seed load and advance enable.
module sodor5_lfsr32 #(
    parameter logic [31:0] RESET_SEED = 32'h00000001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] value
);
    import sodor5_verif_pkg::*;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            value <= fix_seed(RESET_SEED);
        else if (load)
            value <= fix_seed(seed);
        else if (advance)
            value <= lfsr_next(value);
    end

endmodule

// File: rtl/sodor5_stim_sequencer.sv
// sodor5_stim_sequencer: initializes RF/DMEM under core reset, then streams random R-type
// instructions with valid/ready flow control followed by a NOP drain.
module sodor5_stim_sequencer #(
    parameter int          NUM_REGS     = 32,
    parameter int          DMEM_WORDS   = 16,
    parameter int          NUM_INSTRS   = 100,
    parameter int          DRAIN_CYCLES = 5,
    parameter logic [31:0] SEED         = 32'h000003F2,
    localparam int         AW           = $clog2(DMEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          instr_ready,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_waddr,
    output logic [31:0]   dmem_wdata,
    output logic          core_reset,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic          busy,
    output logic          done,
    output logic [15:0]   instr_count
);
    import sodor5_verif_pkg::*;

    localparam logic [15:0] RF_LAST    = 16'(NUM_REGS - 1);
    localparam logic [15:0] DMEM_LAST  = 16'(DMEM_WORDS - 1);
    localparam logic [15:0] INSTR_LAST = 16'(NUM_INSTRS - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] idx;
    logic [31:0] lfsr;
    logic        idle_like, launch, xfer;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign launch    = idle_like && start;
    assign xfer      = instr_valid && instr_ready;

    sodor5_lfsr32 #(.RESET_SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (launch),
        .seed    (SEED),
        .advance ((state == S_RF_INIT) || (state == S_RUN && xfer)),
        .value   (lfsr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: state_nxt = start ? S_RF_INIT : state;
            S_RF_INIT:      state_nxt = (idx == RF_LAST) ? S_DMEM_INIT : state;
            S_DMEM_INIT:    state_nxt = (idx == DMEM_LAST) ? S_RUN : state;
            S_RUN:          state_nxt = (xfer && instr_count == INSTR_LAST) ? S_DRAIN : state;
            S_DRAIN:        state_nxt = (xfer && idx == DRAIN_LAST) ? S_DONE : state;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // One index serves every phase; it restarts at 0 whenever the phase changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            idx <= 16'd0;
        else if (state_nxt != state)
            idx <= 16'd0;
        else if (state == S_RF_INIT || state == S_DMEM_INIT || (state == S_DRAIN && xfer))
            idx <= idx + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            instr_count <= 16'd0;
        else if (launch)
            instr_count <= 16'd0;
        else if (state == S_RUN && xfer)
            instr_count <= instr_count + 16'd1;
    end

    always_comb begin
        rf_we       = state == S_RF_INIT;
        rf_waddr    = idx[4:0];
        rf_wdata    = lfsr;
        dmem_we     = state == S_DMEM_INIT;
        dmem_waddr  = idx[AW-1:0];
        dmem_wdata  = {8{idx[3:0]}};
        core_reset  = (state == S_IDLE) || (state == S_RF_INIT) || (state == S_DMEM_INIT);
        instr_valid = (state == S_RUN) || (state == S_DRAIN);
        instr       = (state == S_RUN) ? {7'd0, lfsr[17:13], lfsr[12:8], lfsr[7:5], lfsr[4:0], OPC_RTYPE} : NOP;
        busy        = !idle_like;
        done        = state == S_DONE;
    end

endmodule

// File: tb/tb_sodor5_stim_sequencer.sv
// tb_sodor5_stim_sequencer: directed checks of init, stall, run length, ignored start and async reset.
module tb_sodor5_stim_sequencer;

    localparam logic [31:0] NOP_W = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        instr_ready = 1'b0;
    logic        rf_we, dmem_we, core_reset, instr_valid, busy, done;
    logic [4:0]  rf_waddr;
    logic [3:0]  dmem_waddr;
    logic [31:0] rf_wdata, dmem_wdata, instr;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    sodor5_stim_sequencer #(
        .NUM_REGS(32), .DMEM_WORDS(16), .NUM_INSTRS(4), .DRAIN_CYCLES(5), .SEED(32'h00000001)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .instr_ready(instr_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
        .core_reset(core_reset), .instr(instr), .instr_valid(instr_valid),
        .busy(busy), .done(done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
    endfunction

    function automatic logic [31:0] model_rtype(input logic [31:0] l);
        logic [4:0] rs2, rs1, rd;
        logic [2:0] f3;
        rs2 = l[17:13];
        rs1 = l[12:8];
        f3  = l[7:5];
        rd  = l[4:0];
        return {7'b0000000, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    initial begin
        logic [31:0] m;
        logic [31:0] held;
        logic [31:0] first3 [3];
        int cyc;
        first3[0] = 32'h00000001;
        first3[1] = 32'h80200003;
        first3[2] = 32'hC0300002;

        #12;
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_instr", instr, NOP_W);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {16'd0, instr_count}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        reset_n = 1'b1;
        step();

        start = 1'b1;
        step();
        start = 1'b0;
        m = 32'h00000001;
        for (int i = 0; i < 32; i++) begin
            check("rf_we", {31'd0, rf_we}, 32'd1);
            check("rf_waddr", {27'd0, rf_waddr}, 32'(i));
            if (i < 3) check("rf_wdata_hand", rf_wdata, first3[i]);
            check("rf_wdata", rf_wdata, m);
            check("rf_core_reset", {31'd0, core_reset}, 32'd1);
            m = model_next(m);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            check("dmem_we", {31'd0, dmem_we}, 32'd1);
            check("dmem_rf_we_off", {31'd0, rf_we}, 32'd0);
            check("dmem_waddr", {28'd0, dmem_waddr}, 32'(i));
            check("dmem_core_reset", {31'd0, core_reset}, 32'd1);
            if (i == 5) check("dmem_word5", dmem_wdata, 32'h55555555);
            if (i == 10) check("dmem_word10", dmem_wdata, 32'hAAAAAAAA);
            start = (i == 3);
            step();
        end
        start = 1'b0;

        check("run_valid", {31'd0, instr_valid}, 32'd1);
        check("run_dmem_we_off", {31'd0, dmem_we}, 32'd0);
        check("run_core_reset", {31'd0, core_reset}, 32'd0);
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_instr0", instr, model_rtype(m));
        held = instr;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", instr, held);
            check("stall_count", {16'd0, instr_count}, 32'd0);
        end
        instr_ready = 1'b1;
        step();
        m = model_next(m);
        check("xfer1_count", {16'd0, instr_count}, 32'd1);
        check("xfer1_instr", instr, model_rtype(m));
        instr_ready = 1'b0;
        step();
        check("stall2_count", {16'd0, instr_count}, 32'd1);
        instr_ready = 1'b1;
        step();
        check("xfer2_count", {16'd0, instr_count}, 32'd2);

        reset_n = 1'b0;
        #1;
        check("arst_core_reset", {31'd0, core_reset}, 32'd1);
        check("arst_count", {16'd0, instr_count}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_instr", instr, NOP_W);
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        #4;
        reset_n = 1'b1;
        step();

        start = 1'b1;
        step();
        start = 1'b0;
        m = 32'h00000001;
        cyc = 1;
        while (!instr_valid && cyc < 200) begin
            if (cyc <= 3) check("restart_rf_wdata", rf_wdata, first3[cyc-1]);
            if (rf_we) m = model_next(m);
            step();
            cyc++;
        end
        check("first_rtype_cycle", 32'(cyc), 32'd49);

        for (int k = 0; k < 4; k++) begin
            check("rtype_instr", instr, model_rtype(m));
            check("rtype_opcode", {25'd0, instr[6:0]}, 32'h33);
            check("rtype_funct7", {25'd0, instr[31:25]}, 32'd0);
            check("rtype_valid", {31'd0, instr_valid}, 32'd1);
            check("rtype_count", {16'd0, instr_count}, 32'(k));
            m = model_next(m);
            step();
        end
        for (int k = 0; k < 5; k++) begin
            check("drain_instr", instr, NOP_W);
            check("drain_valid", {31'd0, instr_valid}, 32'd1);
            check("drain_count", {16'd0, instr_count}, 32'd4);
            check("drain_done", {31'd0, done}, 32'd0);
            step();
        end
        check("done_done", {31'd0, done}, 32'd1);
        check("done_valid", {31'd0, instr_valid}, 32'd0);
        check("done_count", {16'd0, instr_count}, 32'd4);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_instr", instr, NOP_W);
        check("done_core_reset", {31'd0, core_reset}, 32'd0);
        step();
        check("done_hold", {31'd0, done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
